dma_w_burst_gen: RTL

//  Upstream feeder for the AXI-4 DMA write master. Takes one transfer command
//  (start byte address, word count), splits it into AXI bursts that never exceed
//  MAX_BURST beats or cross a 4 KB boundary, and streams source data into the

---
 rtl/dma_w_burst_gen_pkg.sv | 23 ++
 rtl/dma_w_burst_len.sv | 37 +++
 rtl/dma_w_burst_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dma_w_burst_gen_pkg.sv
// Shared definitions for the DMA write burst generator.
//   AXI_ADDR_W / AXI_LEN_W : AXI address width and burst length field width
//   DMA_4K_BYTES           : AXI bursts must not cross this byte boundary
//   state_e                : burst generator FSM states
//   bytes_log2()           : log2 of the byte count of a data word
package dma_w_burst_gen_pkg;

    localparam int unsigned AXI_ADDR_W   = 32;
    localparam int unsigned AXI_LEN_W    = 8;
    localparam int unsigned DMA_4K_BYTES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BURST = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic int unsigned bytes_log2(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dma_w_burst_len.sv
// Burst length calculator (combinational).
// Returns min(remaining, MAX_BURST, words left before the next 4 KB boundary).
//   remaining in  XFER_W        words still to move (non-zero when used)
//   addr_lo   in  12            low 12 bits of the burst start byte address
//   beats     out AXI_LEN_W+1   beats for the next burst (MAX_BURST fits)
module dma_w_burst_len
    import dma_w_burst_gen_pkg::*;
#(
    parameter int unsigned XFER_W     = 16,
    parameter int unsigned MAX_BURST  = 256,
    parameter int unsigned LOG2_BYTES = 2
) (
    input  logic [XFER_W-1:0]  remaining,
    input  logic [11:0]        addr_lo,
    output logic [AXI_LEN_W:0] beats
);

    logic [31:0] dist_words;
    logic [31:0] rem_words;
    logic [31:0] limit;

    always_comb begin
        // Distance to the boundary is 1..1024 words for 4-byte data, so a
        // 32-bit working width holds every candidate without overflow.
        dist_words = (DMA_4K_BYTES - {20'd0, addr_lo}) >> LOG2_BYTES;
        rem_words  = 32'(remaining);
        limit      = MAX_BURST;
        if (dist_words < limit) begin
            limit = dist_words;
        end
        if (rem_words < limit) begin
            limit = rem_words;
        end
        beats = limit[AXI_LEN_W:0];
    end

endmodule

// File: rtl/dma_w_burst_gen.sv
// DMA write burst generator: splits one transfer command into AXI-legal bursts
// (<= MAX_BURST beats, no 4 KB crossing) and streams source data into the
// write master's native port one burst at a time.
//   clk, rst            clock, asynchronous active-high reset
//   start               1-cycle command strobe, ignored while busy
//   start_addr          transfer byte address (low word-offset bits dropped)
//   xfer_words          words to move, 0 = empty transfer
//   busy / done / error transfer status; error is held until the next start
//   s_valid/s_data/s_ready  source data stream
//   dma_len, addr       burst beats-1 and burst start address to write master
//   dma_ready           write master idle; dma_error sticky bresp error
//   valid / ready       native data handshake; wdata = s_data, wstrb = all ones
module dma_w_burst_gen
    import dma_w_burst_gen_pkg::*;
#(
    parameter int unsigned ADDR_W     = AXI_ADDR_W,
    parameter int unsigned DMA_DATA_W = 32,
    parameter int unsigned XFER_W     = 16,
    parameter int unsigned MAX_BURST  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic [XFER_W-1:0]       xfer_words,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic                    s_valid,
    input  logic [DMA_DATA_W-1:0]   s_data,
    output logic                    s_ready,
    output logic [AXI_LEN_W-1:0]    dma_len,
    input  logic                    dma_ready,
    input  logic                    dma_error,
    output logic                    valid,
    input  logic                    ready,
    output logic [ADDR_W-1:0]       addr,
    output logic [DMA_DATA_W-1:0]   wdata,
    output logic [DMA_DATA_W/8-1:0] wstrb
);

    localparam int unsigned        LOG2_BYTES = bytes_log2(DMA_DATA_W);
    localparam logic [AXI_LEN_W:0] ONE_BEAT   = (AXI_LEN_W + 1)'(1);
    localparam logic [ADDR_W-1:0]  ALIGN_MASK =
        ~((ADDR_W'(1) << LOG2_BYTES) - ADDR_W'(1));

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [XFER_W-1:0]      rem_q, rem_d;
    logic [AXI_LEN_W:0]     beats_q, beats_d;
    logic [AXI_LEN_W:0]     cnt_q, cnt_d;
    logic [AXI_LEN_W-1:0]   len_q, len_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [ADDR_W-1:0]      start_addr_al;
    logic [ADDR_W-1:0]      addr_adv;
    logic [XFER_W-1:0]      rem_adv;
    logic [XFER_W-1:0]      len_rem;
    logic [11:0]            len_addr_lo;
    logic [AXI_LEN_W:0]     len_beats;

    assign start_addr_al = start_addr & ALIGN_MASK;
    assign addr_adv      = addr_q + (ADDR_W'(beats_q) << LOG2_BYTES);
    assign rem_adv       = rem_q - XFER_W'(beats_q);

    // The length calculator always looks at the values that will be live on
    // the next ISSUE entry: the new command from IDLE, the advanced pointers
    // from RESP. beats is therefore registered on entry to ISSUE.
    assign len_addr_lo = (state_q == ST_IDLE) ? start_addr_al[11:0] : addr_adv[11:0];
    assign len_rem     = (state_q == ST_IDLE) ? xfer_words : rem_adv;

    dma_w_burst_len #(
        .XFER_W     (XFER_W),
        .MAX_BURST  (MAX_BURST),
        .LOG2_BYTES (LOG2_BYTES)
    ) u_burst_len (
        .remaining (len_rem),
        .addr_lo   (len_addr_lo),
        .beats     (len_beats)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        valid   = 1'b0;
        s_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d = start_addr_al;
                    rem_d  = xfer_words;
                    err_d  = 1'b0;
                    if (xfer_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        beats_d = len_beats;
                        len_d   = AXI_LEN_W'(len_beats - ONE_BEAT);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                valid = s_valid;
                if (dma_ready && s_valid) begin
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                valid   = s_valid;
                s_ready = ready;
                if (s_valid && ready) begin
                    if (cnt_q == beats_q - ONE_BEAT) begin
                        cnt_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q + ONE_BEAT;
                    end
                end
            end
            ST_RESP: begin
                if (dma_ready) begin
                    err_d  = err_q | dma_error;
                    addr_d = addr_adv;
                    rem_d  = rem_adv;
                    if (rem_adv == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        beats_d = len_beats;
                        len_d   = AXI_LEN_W'(len_beats - ONE_BEAT);
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = err_q;
    assign addr    = addr_q;
    assign dma_len = len_q;
    assign wdata   = s_data;
    assign wstrb   = '1;

endmodule
